// File: rtl/mux_nway_reg.sv
// mux_nway_reg: registered N-channel, W-bit multiplexer with direct-select or round-robin arbitration.
// Latency: 1 cycle from input transfer to out_valid; sustains 1 beat/cycle with out_ready held high.
// Backpressure: when out_valid=1 and out_ready=0 the output beat holds and all in_ready bits are low.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous active-high reset
//   mode       0 = direct select, 1 = round-robin
//   select     channel index used in direct mode
//   in_data    flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel accept (combinational, at most one bit high)
//   out_data   registered winning data
//   out_src    registered index of the winning channel
//   out_valid  output register holds a beat
//   out_ready  consumer accepts the beat
module mux_nway_reg #(
  parameter int WIDTH    = 5,
  parameter int CHANNELS = 4,
  parameter int SEL_W    = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_src,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // CHANNELS at pointer width + 1, so sums of two in-range indices never overflow.
  localparam logic [SEL_W:0]   CH_L     = (SEL_W+1)'(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(CHANNELS - 1);

  logic [WIDTH-1:0] r_out_data;
  logic [SEL_W-1:0] r_out_src;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_rr_ptr;

  logic             w_load_en;
  logic             w_dir_vld;
  logic [SEL_W-1:0] w_rr_grant;
  logic             w_rr_vld;
  logic [SEL_W-1:0] w_grant;
  logic             w_grant_vld;
  logic [WIDTH-1:0] w_grant_data;

  // Output register is empty, or its beat leaves this cycle.
  assign w_load_en = !r_out_valid || out_ready;

  // Direct mode: comparing select against every real channel index means an
  // out-of-range select simply matches nothing and never grants.
  always_comb begin
    w_dir_vld = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (select == SEL_W'(i) && in_valid[i]) begin
        w_dir_vld = 1'b1;
      end
    end
  end

  // Round-robin: scan rr_ptr, rr_ptr+1, ... modulo CHANNELS; the first valid
  // channel wins. The wrap subtracts CHANNELS rather than dropping the carry,
  // so non-power-of-two channel counts wrap correctly.
  always_comb begin
    logic [SEL_W:0]   v_sum;
    logic [SEL_W-1:0] v_idx;
    logic             v_found;
    w_rr_grant = '0;
    v_found    = 1'b0;
    v_sum      = '0;
    v_idx      = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      v_sum = {1'b0, r_rr_ptr} + (SEL_W+1)'(k);
      if (v_sum >= CH_L) begin
        v_sum = v_sum - CH_L;
      end
      v_idx = v_sum[SEL_W-1:0];
      for (int i = 0; i < CHANNELS; i++) begin
        if (!v_found && v_idx == SEL_W'(i) && in_valid[i]) begin
          v_found    = 1'b1;
          w_rr_grant = v_idx;
        end
      end
    end
    w_rr_vld = |in_valid;
  end

  assign w_grant     = mode ? w_rr_grant : select;
  assign w_grant_vld = mode ? w_rr_vld   : w_dir_vld;

  // One-hot accept towards the winning source; suppressed during reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = !reset && w_load_en && w_grant_vld && (w_grant == SEL_W'(i));
    end
  end

  always_comb begin
    w_grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_grant == SEL_W'(i)) begin
        w_grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_load_en) begin
      if (w_grant_vld) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_grant_data;
        r_out_src   <= w_grant;
        // Pointer only advances on a round-robin transfer; direct-mode
        // traffic leaves it where it was.
        if (mode) begin
          r_rr_ptr <= (w_grant == LAST_IDX) ? '0 : w_grant + 1'b1;
        end
      end else begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_mux_nway_reg.sv
module tb_mux_nway_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        mode;
  logic [1:0]  select;
  logic [19:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [4:0]  out_data;
  logic [1:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  // Three-channel instance for the out-of-range select case.
  logic        mode3;
  logic [1:0]  select3;
  logic [2:0]  in_ready3;
  logic [4:0]  out_data3;
  logic [1:0]  out_src3;
  logic        out_valid3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0] data;
    logic [1:0] src;
  } beat_t;

  beat_t exp_q[$];

  always #5 clk = ~clk;

  mux_nway_reg #(.WIDTH(5), .CHANNELS(4), .SEL_W(2)) dut (
    .clk(clk), .reset(reset), .mode(mode), .select(select),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mux_nway_reg #(.WIDTH(5), .CHANNELS(3), .SEL_W(2)) dut3 (
    .clk(clk), .reset(reset), .mode(mode3), .select(select3),
    .in_data(in_data[14:0]), .in_valid(in_valid[2:0]), .in_ready(in_ready3),
    .out_data(out_data3), .out_src(out_src3), .out_valid(out_valid3),
    .out_ready(1'b1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int i, input logic [4:0] v);
    in_data[i*5 +: 5] = v;
  endtask

  task automatic push(input logic [4:0] d, input logic [1:0] s);
    beat_t b;
    b.data = d;
    b.src  = s;
    exp_q.push_back(b);
  endtask

  // Monitor: a beat leaves the DUT on the next rising edge whenever out_valid
  // and out_ready are both high at the falling edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_beat: got data=%0h src=%0h, expected none", out_data, out_src);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", 32'(out_data), 32'(e.data));
          chk("beat_src",  32'(out_src),  32'(e.src));
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    mode      = 1'b0;
    select    = 2'd0;
    in_data   = '0;
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    mode3     = 1'b0;
    select3   = 2'd3;

    // Reset: no accept while reset is high, cleared outputs afterwards.
    repeat (2) begin
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'h0);
    end
    cyc();
    reset    = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'h0);
    chk("reset_out_data",  32'(out_data),  32'h0);
    chk("reset_out_src",   32'(out_src),   32'h0);
    cyc();

    // Direct accept of channel 2.
    select   = 2'd2;
    in_valid = 4'b0100;
    set_ch(2, 5'h15);
    @(negedge clk);
    chk("direct_in_ready", 32'(in_ready), 32'h4);
    push(5'h15, 2'd2);
    cyc();

    // Direct miss with the previous beat still valid; 3-channel select=3 never grants.
    select   = 2'd1;
    in_valid = 4'b1101;
    @(negedge clk);
    chk("direct_out_valid_prior", 32'(out_valid), 32'h1);
    chk("miss_in_ready", 32'(in_ready), 32'h0);
    chk("ch3_in_ready", 32'(in_ready3), 32'h0);
    cyc();
    @(negedge clk);
    chk("miss_out_valid", 32'(out_valid), 32'h0);
    chk("ch3_out_valid", 32'(out_valid3), 32'h0);

    // Round-robin fairness from a fresh pointer.
    reset    = 1'b1;
    in_valid = 4'b0000;
    cyc();
    reset = 1'b0;
    mode  = 1'b1;
    for (int i = 0; i < 4; i++) set_ch(i, 5'h10 + 5'(i));
    in_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("rr_in_ready", 32'(in_ready), 32'(4'b0001 << (k % 4)));
      push(5'h10 + 5'(k % 4), 2'(k % 4));
      cyc();
    end
    in_valid = 4'b0000;
    cyc();
    cyc();

    // Round-robin skip and wrap over channels 0 and 3.
    reset = 1'b1;
    cyc();
    reset    = 1'b0;
    in_valid = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_wrap_in_ready", 32'(in_ready), (k % 2 == 0) ? 32'h1 : 32'h8);
      push((k % 2 == 0) ? 5'h10 : 5'h13, (k % 2 == 0) ? 2'd0 : 2'd3);
      cyc();
    end
    // No valid inputs: no grant, pointer (now 0) must stay put.
    in_valid = 4'b0000;
    cyc();
    in_valid = 4'b0110;
    @(negedge clk);
    chk("rr_hold_ptr_in_ready", 32'(in_ready), 32'h2);
    push(5'h11, 2'd1);
    cyc();

    // Direct mode leaves the pointer (now 2) alone across the mode switch.
    mode     = 1'b0;
    select   = 2'd0;
    in_valid = 4'b0001;
    @(negedge clk);
    chk("dir_switch_in_ready", 32'(in_ready), 32'h1);
    push(5'h10, 2'd0);
    cyc();
    mode     = 1'b1;
    in_valid = 4'b1111;
    @(negedge clk);
    chk("rr_resume_in_ready", 32'(in_ready), 32'h4);
    push(5'h12, 2'd2);
    cyc();

    // Backpressure: hold the 0A beat from channel 3 for three cycles.
    mode     = 1'b0;
    select   = 2'd3;
    in_valid = 4'b1000;
    set_ch(3, 5'h0A);
    @(negedge clk);
    chk("bp_load_in_ready", 32'(in_ready), 32'h8);
    push(5'h0A, 2'd3);
    cyc();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_ch(3, 5'h1F - 5'(k));
      select = 2'(k);
      mode   = k[0];
      in_valid = 4'b1111;
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'h0);
      chk("bp_out_data", 32'(out_data), 32'h0A);
      chk("bp_out_src",  32'(out_src),  32'h3);
      cyc();
    end
    mode      = 1'b0;
    out_ready = 1'b1;
    select    = 2'd1;
    in_valid  = 4'b0010;
    set_ch(1, 5'h07);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(in_ready), 32'h2);
    push(5'h07, 2'd1);
    cyc();
    in_valid = 4'b0000;
    @(negedge clk);
    chk("bp_no_bubble", 32'(out_valid), 32'h1);
    cyc();

    // Reset while stalled drops the held beat.
    in_valid = 4'b0100;
    select   = 2'd2;
    set_ch(2, 5'h1B);
    @(negedge clk);
    push(5'h1B, 2'd2);
    cyc();
    out_ready = 1'b0;
    in_valid  = 4'b1111;
    reset     = 1'b1;
    @(negedge clk);
    chk("rst_stall_in_ready", 32'(in_ready), 32'h0);
    void'(exp_q.pop_back());
    cyc();
    reset    = 1'b0;
    in_valid = 4'b0000;
    @(negedge clk);
    chk("rst_stall_out_valid", 32'(out_valid), 32'h0);
    out_ready = 1'b1;
    cyc();
    cyc();

    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
